instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter MAX_WORDS, 256, maximum instruction words written per load session.
REQ-002 Parameter ADDR_W, 32, width of the instruction-memory byte address.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session; honoured only in IDLE, DONE or ERR.
REQ-006 base_addr  input  ADDR_W  byte address of the first word, sampled on start; bits [1:0] ignored (forced 0).
REQ-007 in_valid  input  1  instruction-field bundle valid.
REQ-008 in_ready  output  1  encoder can accept a bundle.
REQ-009 in_mnem  input  4  mnemonic: 0 ADDU, 1 SUB, 2 JR, 3 LUI, 4 ORI, 5 ADDI, 6 ADDIU, 7 BEQ, 8 LW, 9 SW, 10 J, 11 JAL; 12-15 illegal.
REQ-010 in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-011 in_imm  input  16  immediate / branch offset.
REQ-012 in_target  input  26  jump target field.
REQ-013 in_last  input  1  bundle is the final one of the session.
REQ-014 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-015 imem_addr  output  ADDR_W  write byte address.
REQ-016 imem_wdata  output  32  encoded instruction word.
REQ-017 word_count  output  9  words written in the current session.
REQ-018 done  output  1  one-cycle pulse after the last word is written.
REQ-019 err  output  1  sticky error flag, cleared only by start or reset.

Function
REQ-020 The FSM SHALL have states IDLE, ACCEPT, WRITE, DONE and ERR.
REQ-021 IDLE/DONE/ERR + start: latch base_addr, clear word_count and err, go to ACCEPT.
REQ-022 in_ready SHALL be 1 only in ACCEPT; a transfer occurs on in_valid&&in_ready.
REQ-023 Transfer with legal mnemonic and word_count<MAX_WORDS: register encoded word into imem_wdata, go to WRITE.
REQ-024 In WRITE: imem_we=1 for exactly one cycle at the current imem_addr. Next cycle: imem_addr+=4 (wraps modulo 2^ADDR_W), word_count+=1, go to DONE if the latched in_last was 1, else ACCEPT.
REQ-025 Latency: transfer at cycle N produces imem_we at cycle N+1. Throughput is one word per 2 cycles.
REQ-026 R-type encoding SHALL be {6'b000000, rs, rt, rd, 5'b0, funct}, with funct ADDU=100001, SUB=100010, JR=001000. JR forces rt and rd to 0.
REQ-027 I-type encoding SHALL be {op, rs, rt, imm}, with op LUI=001111, ORI=001101, ADDI=001000, ADDIU=001001, BEQ=000100, LW=100011, SW=101011. LUI forces rs to 0.
REQ-028 J-type encoding SHALL be {op, target}, with J=000010 and JAL=000011.
REQ-029 Illegal mnemonic, or a transfer with word_count==MAX_WORDS: no write, set err, go to ERR.
REQ-030 In ERR, in_ready=0 and the FSM waits for start.
REQ-031 DONE SHALL assert done for one cycle, then go to IDLE unless start is present.
REQ-032 start in ACCEPT or WRITE SHALL be ignored.
REQ-033 Unused-field inputs SHALL not affect the output word.

Reset
REQ-034 Asynchronous assertion of rst_n=0 SHALL force state IDLE and zero every output and register: in_ready, imem_we, imem_addr, imem_wdata, word_count, done, err.
REQ-035 Reset during WRITE SHALL suppress the pending imem_we in the same cycle.
REQ-036 Release SHALL be synchronous to clk; IDLE is held until start.

Structure
REQ-037 Mnemonic codes, opcode constants and funct constants SHALL live in shared package mips_isa_pkg, which is reused by the control unit.
REQ-038 The encoding SHALL be one combinational sub-module, instr_word_enc (mnem plus fields to 32-bit word plus illegal flag); instr_encoder holds the FSM, address counter and registers.

Verification
REQ-039 start with base 0x00400000; ADDU rs=1 rt=2 rd=3, last=1 -> imem_we at 0x00400000, wdata 0x00221821; done one cycle later.
REQ-040 Stream LUI rt=1 imm=0x1001, LW rt=8 rs=29 imm=4, J target=0x0100000 (last) -> words 0x3C011001, 0x8FA80004, 0x08100000 at +0, +4, +8; word_count=3.
REQ-041 in_mnem=13 -> no imem_we, err=1, in_ready=0; next start clears err.
REQ-042 MAX_WORDS=2, send 3 bundles -> 2 writes, then err=1 on the third transfer.
REQ-043 base 0xFFFFFFFC, 2 words -> second write at 0x00000000.
REQ-044 rst_n low in the WRITE cycle -> imem_we=0 immediately, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: encoder mnemonic codes, primary opcodes and R-type funct fields.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    MN_ADDU  = 4'd0,
    MN_SUB   = 4'd1,
    MN_JR    = 4'd2,
    MN_LUI   = 4'd3,
    MN_ORI   = 4'd4,
    MN_ADDI  = 4'd5,
    MN_ADDIU = 4'd6,
    MN_BEQ   = 4'd7,
    MN_LW    = 4'd8,
    MN_SW    = 4'd9,
    MN_J     = 4'd10,
    MN_JAL   = 4'd11
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

endpackage

// File: rtl/instr_word_enc.sv
// Combinational mnemonic + field encoder producing one 32-bit MIPS instruction word.
module instr_word_enc
  import mips_isa_pkg::*;
(
  input  logic [3:0]  i_mnem,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    // Fields a format does not carry are simply left out of the concatenation.
    case (mnem_e'(i_mnem))
      MN_ADDU:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'b0, FN_ADDU};
      MN_SUB:   o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'b0, FN_SUB};
      MN_JR:    o_word = {OP_RTYPE, i_rs, 5'b0, 5'b0, 5'b0, FN_JR};
      MN_LUI:   o_word = {OP_LUI, 5'b0, i_rt, i_imm};
      MN_ORI:   o_word = {OP_ORI, i_rs, i_rt, i_imm};
      MN_ADDI:  o_word = {OP_ADDI, i_rs, i_rt, i_imm};
      MN_ADDIU: o_word = {OP_ADDIU, i_rs, i_rt, i_imm};
      MN_BEQ:   o_word = {OP_BEQ, i_rs, i_rt, i_imm};
      MN_LW:    o_word = {OP_LW, i_rs, i_rt, i_imm};
      MN_SW:    o_word = {OP_SW, i_rs, i_rt, i_imm};
      MN_J:     o_word = {OP_J, i_target};
      MN_JAL:   o_word = {OP_JAL, i_target};
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Load-session controller: accepts field bundles, encodes them and writes words
// to sequential instruction-memory addresses, one word per two cycles.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [8:0]        word_count,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [8:0] MAX_CNT = 9'(MAX_WORDS);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [8:0]        r_count;
  logic              r_err;
  logic              r_last;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_unused_base_lsb;

  assign w_unused_base_lsb = ^base_addr[1:0];

  instr_word_enc u_enc (
    .i_mnem    (in_mnem),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // Strobes decode straight from state so an asynchronous reset kills them immediately.
  assign in_ready   = (r_state == S_ACCEPT);
  assign imem_we    = (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_count;
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
            r_count <= '0;
            r_err   <= 1'b0;
            r_state <= S_ACCEPT;
          end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            // A full session counts as an error just like an unknown mnemonic.
            if (w_illegal || (r_count >= MAX_CNT)) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_wdata <= w_word;
              r_last  <= in_last;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + ADDR_W'(4);
          r_count <= r_count + 9'd1;
          r_state <= r_last ? S_DONE : S_ACCEPT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of single-word sessions plus stream, session-limit,
// address-wrap and reset-in-WRITE sequences, with a write scoreboard.
module tb_instr_encoder;
  import mips_isa_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  logic        in_ready, imem_we, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  word_count;

  logic        in_ready2, imem_we2, err2, unused_done2;
  logic [31:0] unused_addr2, unused_wdata2;
  logic [8:0]  unused_wc2;

  instr_encoder #(.MAX_WORDS(256), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
    .done(done), .err(err)
  );

  instr_encoder #(.MAX_WORDS(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we2),
    .imem_addr(unused_addr2), .imem_wdata(unused_wdata2), .word_count(unused_wc2),
    .done(unused_done2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] base;
    logic        illegal;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          w2_cnt   = 0;
  int          w2_snap;

  function automatic vec_t mk(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                              input logic [31:0] base, input logic ill, input logic [31:0] w);
    vec_t v;
    v.mnem = m; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.tgt = tgt;
    v.base = base; v.illegal = ill; v.word = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample write strobes on the falling edge, return just after the rising edge.
  task automatic step();
    logic [63:0] e;
    @(negedge clk);
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {32'b0, imem_addr}, {32'b0, e[63:32]});
        chk("wr_data", {32'b0, imem_wdata}, {32'b0, e[31:0]});
      end
    end
    if (rst_n && imem_we2) w2_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    step();
    start = 1'b0;
    chk("start_ready", {63'b0, in_ready}, 64'd1);
    chk("start_err_clr", {63'b0, err}, 64'd0);
    chk("start_wc_clr", {55'b0, word_count}, 64'd0);
  endtask

  task automatic send(input vec_t v, input logic last, input logic exp_we);
    int t;
    t = 0;
    in_valid = 1'b1; in_mnem = v.mnem; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_imm = v.imm; in_target = v.tgt; in_last = last;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("we_latency", {63'b0, imem_we}, {63'b0, exp_we});
  endtask

  task automatic check_done(input logic [8:0] wc);
    step();
    chk("done_pulse", {63'b0, done}, 64'd1);
    chk("done_wc", {55'b0, word_count}, {55'b0, wc});
    step();
    chk("done_low", {63'b0, done}, 64'd0);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = mk(MN_ADDU,  5'd1,  5'd2,  5'd3,  16'hBEEF, 26'h2AAAAAA, 32'h0040_0000, 1'b0, 32'h0022_1821);
    vecs[1]  = mk(MN_SUB,   5'd4,  5'd5,  5'd6,  16'h1234, 26'h1555555, 32'h0000_1000, 1'b0, 32'h0085_3022);
    vecs[2]  = mk(MN_JR,    5'd31, 5'd7,  5'd9,  16'hFFFF, 26'h3FFFFFF, 32'h0000_2000, 1'b0, 32'h03E0_0008);
    vecs[3]  = mk(MN_LUI,   5'd5,  5'd1,  5'd22, 16'h1001, 26'h0000001, 32'h0000_3000, 1'b0, 32'h3C01_1001);
    vecs[4]  = mk(MN_ORI,   5'd1,  5'd1,  5'd17, 16'h00FF, 26'h2222222, 32'h0040_0003, 1'b0, 32'h3421_00FF);
    vecs[5]  = mk(MN_ADDI,  5'd2,  5'd3,  5'd31, 16'hFFFE, 26'h1111111, 32'h0000_4000, 1'b0, 32'h2043_FFFE);
    vecs[6]  = mk(MN_ADDIU, 5'd29, 5'd29, 5'd8,  16'hFFF8, 26'h0ABCDEF, 32'h0000_5000, 1'b0, 32'h27BD_FFF8);
    vecs[7]  = mk(MN_BEQ,   5'd4,  5'd5,  5'd0,  16'h0003, 26'h3000000, 32'h0000_6000, 1'b0, 32'h1085_0003);
    vecs[8]  = mk(MN_SW,    5'd29, 5'd31, 5'd12, 16'h001C, 26'h0F0F0F0, 32'h0000_7000, 1'b0, 32'hAFBF_001C);
    vecs[9]  = mk(MN_JAL,   5'd3,  5'd9,  5'd27, 16'hAAAA, 26'h3FFFFFF, 32'h0000_8000, 1'b0, 32'h0FFF_FFFF);
    vecs[10] = mk(4'd13,    5'd1,  5'd2,  5'd3,  16'h0001, 26'h0000000, 32'h0000_9000, 1'b1, 32'h0);
    vecs[11] = mk(4'd15,    5'd1,  5'd2,  5'd3,  16'h0001, 26'h0000000, 32'h0000_A000, 1'b1, 32'h0);

    rst_n = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_mnem = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_we", {63'b0, imem_we}, 64'd0);
    chk("rst_addr", {32'b0, imem_addr}, 64'd0);
    chk("rst_wdata", {32'b0, imem_wdata}, 64'd0);
    chk("rst_wc", {55'b0, word_count}, 64'd0);
    chk("rst_done_err", {62'b0, done, err}, 64'd0);
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_hold", {63'b0, in_ready}, 64'd0);

    // Single-word sessions driven from the vector table.
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      do_start(v.base);
      if (!v.illegal) exp_q.push_back({v.base & 32'hFFFF_FFFC, v.word});
      send(v, 1'b1, !v.illegal);
      if (!v.illegal) begin
        check_done(9'd1);
      end else begin
        chk("illegal_err", {63'b0, err}, 64'd1);
        chk("illegal_ready", {63'b0, in_ready}, 64'd0);
        step();
        chk("illegal_sticky", {62'b0, err, imem_we}, 64'd2);
        chk("sb_drain_ill", 64'(exp_q.size()), 64'd0);
      end
    end

    // Three-word stream; a start pulse during WRITE must be ignored.
    do_start(32'h0040_0000);
    exp_q.push_back({32'h0040_0000, 32'h3C01_1001});
    exp_q.push_back({32'h0040_0004, 32'h8FA8_0004});
    exp_q.push_back({32'h0040_0008, 32'h0810_0000});
    send(mk(MN_LUI, 5'd0, 5'd1, 5'd0, 16'h1001, 26'h0, 32'h0, 1'b0, 32'h0), 1'b0, 1'b1);
    start = 1'b1;
    base_addr = 32'h1234_0000;
    step();
    start = 1'b0;
    send(mk(MN_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 32'h0, 1'b0, 32'h0), 1'b0, 1'b1);
    send(mk(MN_J, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0100000, 32'h0, 1'b0, 32'h0), 1'b1, 1'b1);
    check_done(9'd3);

    // Session limit: the MAX_WORDS=2 instance errors on its third transfer.
    do_start(32'h0000_2000);
    chk("max_err_clr", {63'b0, err2}, 64'd0);
    w2_snap = w2_cnt;
    exp_q.push_back({32'h0000_2000, 32'h0022_1821});
    exp_q.push_back({32'h0000_2004, 32'h0022_1821});
    exp_q.push_back({32'h0000_2008, 32'h0022_1821});
    send(vecs[0], 1'b0, 1'b1);
    send(vecs[0], 1'b0, 1'b1);
    send(vecs[0], 1'b1, 1'b1);
    chk("max_err", {63'b0, err2}, 64'd1);
    chk("max_ready", {63'b0, in_ready2}, 64'd0);
    check_done(9'd3);
    chk("max_writes", 64'(w2_cnt - w2_snap), 64'd2);
    chk("max_no_we", {63'b0, imem_we2}, 64'd0);

    // Address wrap past the top of the address space.
    do_start(32'hFFFF_FFFC);
    chk("max_err_restart", {63'b0, err2}, 64'd0);
    exp_q.push_back({32'hFFFF_FFFC, 32'h3421_00FF});
    exp_q.push_back({32'h0000_0000, 32'h3421_00FF});
    send(vecs[4], 1'b0, 1'b1);
    send(vecs[4], 1'b1, 1'b1);
    check_done(9'd2);

    // Reset asserted during the WRITE cycle.
    do_start(32'h0000_1000);
    send(vecs[1], 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_we", {63'b0, imem_we}, 64'd0);
    chk("wr_rst_ready", {63'b0, in_ready}, 64'd0);
    chk("wr_rst_addr", {32'b0, imem_addr}, 64'd0);
    chk("wr_rst_wdata", {32'b0, imem_wdata}, 64'd0);
    chk("wr_rst_wc", {55'b0, word_count}, 64'd0);
    chk("wr_rst_done_err", {62'b0, done, err}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("wr_rst_idle", {62'b0, in_ready, imem_we}, 64'd0);
    chk("sb_final", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
